temporal_ngram_encoder: RTL and testbench

//  Upstream stage of the associative memory. Builds an N-gram hypervector for each of the

---
 rtl/temporal_ngram_encoder_if.sv | 26 ++
 rtl/temporal_ngram_encoder.sv | 128 ++++++++++++
 tb/tb_temporal_ngram_encoder.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/temporal_ngram_encoder_if.sv
// Bundles the spatial-HV input and N-gram output handshakes of temporal_ngram_encoder.
// Valid/ready semantics: a transfer happens on the rising clock edge where Valid and Ready are both 1.
interface temporal_ngram_encoder_if #(
   parameter int HV_DIMENSION = 2000
);
   logic                      ValidIn_SI;
   logic                      ReadyOut_SO;
   logic [0:HV_DIMENSION-1]   SpatialHV_mod1_DI;
   logic [0:HV_DIMENSION-1]   SpatialHV_mod2_DI;
   logic [0:HV_DIMENSION-1]   SpatialHV_mod3_DI;
   logic                      ValidOut_SO;
   logic                      ReadyIn_SI;
   logic [0:HV_DIMENSION-1]   NgramHV_mod1_DO;
   logic [0:HV_DIMENSION-1]   NgramHV_mod2_DO;
   logic [0:HV_DIMENSION-1]   NgramHV_mod3_DO;

   modport master (
      input  ValidIn_SI, SpatialHV_mod1_DI, SpatialHV_mod2_DI, SpatialHV_mod3_DI, ReadyIn_SI,
      output ReadyOut_SO, ValidOut_SO, NgramHV_mod1_DO, NgramHV_mod2_DO, NgramHV_mod3_DO
   );

   modport slave (
      output ValidIn_SI, SpatialHV_mod1_DI, SpatialHV_mod2_DI, SpatialHV_mod3_DI, ReadyIn_SI,
      input  ReadyOut_SO, ValidOut_SO, NgramHV_mod1_DO, NgramHV_mod2_DO, NgramHV_mod3_DO
   );
endinterface

// File: rtl/temporal_ngram_encoder.sv
// Builds per-modality N-gram hypervectors: newest sample XOR progressively rotated history,
// emitted for all three modalities under one valid/ready handshake.
module temporal_ngram_encoder #(
   parameter int HV_DIMENSION = 2000,
   parameter int NGRAM_SIZE   = 3
) (
   input  logic                      Clk_CI,
   input  logic                      Reset_RBI,
   input  logic                      Clear_SI,
   temporal_ngram_encoder_if.master  Bus_S,
   output logic [0:0]                State_SO
);

   localparam int CNT_W = $clog2(NGRAM_SIZE + 1);
   localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(NGRAM_SIZE - 1);

   localparam logic [0:0] IDLE          = 1'b0;
   localparam logic [0:0] OUTPUT_STABLE = 1'b1;

   typedef logic [0:HV_DIMENSION-1] hv_t;

   // rho: rotate one position toward higher index, top bit wraps to index 0
   function automatic hv_t rho(input hv_t x);
      return {x[HV_DIMENSION-1], x[0:HV_DIMENSION-2]};
   endfunction

   logic [0:0]       state_DP;
   logic [CNT_W-1:0] fillCntr_DP;
   logic             readyArm_SP;
   logic             accept_S;
   hv_t              sampleIn_D [3];
   hv_t              ngramNext_D [3];
   hv_t              ngram_DP [3];

   always_comb begin
      sampleIn_D[0] = Bus_S.SpatialHV_mod1_DI;
      sampleIn_D[1] = Bus_S.SpatialHV_mod2_DI;
      sampleIn_D[2] = Bus_S.SpatialHV_mod3_DI;
   end

   // readyArm_SP keeps ReadyOut low while in reset and for the first edge after release
   assign Bus_S.ReadyOut_SO = readyArm_SP & (state_DP == IDLE) & ~Clear_SI;
   assign Bus_S.ValidOut_SO = (state_DP == OUTPUT_STABLE);
   assign accept_S          = Bus_S.ValidIn_SI & Bus_S.ReadyOut_SO;
   assign State_SO          = state_DP;

   assign Bus_S.NgramHV_mod1_DO = ngram_DP[0];
   assign Bus_S.NgramHV_mod2_DO = ngram_DP[1];
   assign Bus_S.NgramHV_mod3_DO = ngram_DP[2];

   if (NGRAM_SIZE > 1) begin : g_hist
      // hist_DP[m][0] is the newest stored sample, hist_DP[m][NGRAM_SIZE-2] the oldest
      hv_t hist_DP [3][NGRAM_SIZE-1];

      always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
         if (!Reset_RBI) begin
            for (int m = 0; m < 3; m++)
               for (int k = 0; k < NGRAM_SIZE - 1; k++)
                  hist_DP[m][k] <= '0;
         end else if (Clear_SI) begin
            for (int m = 0; m < 3; m++)
               for (int k = 0; k < NGRAM_SIZE - 1; k++)
                  hist_DP[m][k] <= '0;
         end else if (accept_S) begin
            for (int m = 0; m < 3; m++) begin
               hist_DP[m][0] <= sampleIn_D[m];
               for (int k = 1; k < NGRAM_SIZE - 1; k++)
                  hist_DP[m][k] <= hist_DP[m][k-1];
            end
         end
      end

      always_comb begin
         hv_t rot;
         for (int m = 0; m < 3; m++) begin
            ngramNext_D[m] = sampleIn_D[m];
            for (int k = 1; k < NGRAM_SIZE; k++) begin
               rot = hist_DP[m][k-1];
               for (int j = 0; j < k; j++)
                  rot = rho(rot);
               ngramNext_D[m] = ngramNext_D[m] ^ rot;
            end
         end
      end
   end else begin : g_nohist
      always_comb begin
         for (int m = 0; m < 3; m++)
            ngramNext_D[m] = sampleIn_D[m];
      end
   end

   always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
      if (!Reset_RBI) begin
         state_DP    <= IDLE;
         fillCntr_DP <= '0;
         readyArm_SP <= 1'b0;
         for (int m = 0; m < 3; m++)
            ngram_DP[m] <= '0;
      end else begin
         readyArm_SP <= 1'b1;
         if (Clear_SI) begin
            // a pending N-gram is dropped; the output registers simply go stale
            state_DP    <= IDLE;
            fillCntr_DP <= '0;
         end else begin
            case (state_DP)
               IDLE: begin
                  if (accept_S) begin
                     if (fillCntr_DP == FILL_MAX) begin
                        for (int m = 0; m < 3; m++)
                           ngram_DP[m] <= ngramNext_D[m];
                        state_DP <= OUTPUT_STABLE;
                     end else begin
                        fillCntr_DP <= fillCntr_DP + 1'b1;
                     end
                  end
               end
               OUTPUT_STABLE: begin
                  if (Bus_S.ReadyIn_SI)
                     state_DP <= IDLE;
               end
               default: state_DP <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_temporal_ngram_encoder.sv
// Directed bench for temporal_ngram_encoder with HV_DIMENSION=8 (literals written bit0..bit7),
// one instance with NGRAM_SIZE=3 and one with NGRAM_SIZE=1.
module tb_temporal_ngram_encoder;

   logic clk;
   logic rst_n;
   logic clear1;
   logic clear2;
   logic [0:0] state1;
   logic [0:0] state2;
   int checks;
   int errors;

   temporal_ngram_encoder_if #(.HV_DIMENSION(8)) bus1 ();
   temporal_ngram_encoder_if #(.HV_DIMENSION(8)) bus2 ();

   temporal_ngram_encoder #(.HV_DIMENSION(8), .NGRAM_SIZE(3)) dut1 (
      .Clk_CI(clk), .Reset_RBI(rst_n), .Clear_SI(clear1), .Bus_S(bus1), .State_SO(state1)
   );

   temporal_ngram_encoder #(.HV_DIMENSION(8), .NGRAM_SIZE(1)) dut2 (
      .Clk_CI(clk), .Reset_RBI(rst_n), .Clear_SI(clear2), .Bus_S(bus2), .State_SO(state2)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // driver
   task automatic drive1(input logic v, input logic [0:7] a, input logic [0:7] b, input logic [0:7] c);
      bus1.ValidIn_SI        = v;
      bus1.SpatialHV_mod1_DI = a;
      bus1.SpatialHV_mod2_DI = b;
      bus1.SpatialHV_mod3_DI = c;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      clear1 = 1'b0;
      clear2 = 1'b0;
      drive1(1'b0, 8'b0, 8'b0, 8'b0);
      bus1.ReadyIn_SI        = 1'b1;
      bus2.ValidIn_SI        = 1'b0;
      bus2.SpatialHV_mod1_DI = '0;
      bus2.SpatialHV_mod2_DI = '0;
      bus2.SpatialHV_mod3_DI = '0;
      bus2.ReadyIn_SI        = 1'b0;

      // 1. reset values, ReadyOut one cycle after release
      tick();
      tick();
      check("rst_valid", {7'b0, bus1.ValidOut_SO}, 8'd0);
      check("rst_ready", {7'b0, bus1.ReadyOut_SO}, 8'd0);
      check("rst_ngram1", bus1.NgramHV_mod1_DO, 8'b00000000);
      check("rst_ngram3", bus1.NgramHV_mod3_DO, 8'b00000000);
      rst_n = 1'b1;
      tick();
      check("post_rst_ready", {7'b0, bus1.ReadyOut_SO}, 8'd1);
      check("post_rst_valid", {7'b0, bus1.ValidOut_SO}, 8'd0);
      check("post_rst_ready_n1", {7'b0, bus2.ReadyOut_SO}, 8'd1);

      // 2. warm-up with three identical samples
      drive1(1'b1, 8'b10000000, 8'b01000000, 8'b00000001);
      tick();
      check("warm_s1_valid", {7'b0, bus1.ValidOut_SO}, 8'd0);
      tick();
      check("warm_s2_valid", {7'b0, bus1.ValidOut_SO}, 8'd0);
      tick();
      check("s3_valid", {7'b0, bus1.ValidOut_SO}, 8'd1);
      check("s3_state", {7'b0, state1}, 8'd1);
      check("s3_ready", {7'b0, bus1.ReadyOut_SO}, 8'd0);
      check("s3_mod1", bus1.NgramHV_mod1_DO, 8'b11100000);
      check("s3_mod2", bus1.NgramHV_mod2_DO, 8'b01110000);
      check("s3_mod3", bus1.NgramHV_mod3_DO, 8'b11000001);

      // 3. sliding window: 4th sample (offered during OUTPUT_STABLE, taken after return to IDLE)
      drive1(1'b1, 8'b00000001, 8'b00000000, 8'b00000000);
      tick();
      check("s3_release_valid", {7'b0, bus1.ValidOut_SO}, 8'd0);
      check("s3_release_ready", {7'b0, bus1.ReadyOut_SO}, 8'd1);
      tick();
      check("s4_valid", {7'b0, bus1.ValidOut_SO}, 8'd1);
      check("s4_mod1", bus1.NgramHV_mod1_DO, 8'b01100001);
      check("s4_mod3", bus1.NgramHV_mod3_DO, 8'b11000000);

      // 4. backpressure with toggling inputs
      bus1.ReadyIn_SI = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive1(1'((i + 1) % 2), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)));
         tick();
         check("bp_valid", {7'b0, bus1.ValidOut_SO}, 8'd1);
         check("bp_ready", {7'b0, bus1.ReadyOut_SO}, 8'd0);
         check("bp_mod1", bus1.NgramHV_mod1_DO, 8'b01100001);
      end
      bus1.ReadyIn_SI = 1'b1;
      drive1(1'b0, 8'b0, 8'b0, 8'b0);
      tick();
      check("bp_release_valid", {7'b0, bus1.ValidOut_SO}, 8'd0);
      check("bp_release_ready", {7'b0, bus1.ReadyOut_SO}, 8'd1);
      // history must still be {00000001, 10000000}
      drive1(1'b1, 8'b01000000, 8'b0, 8'b0);
      tick();
      check("sA_valid", {7'b0, bus1.ValidOut_SO}, 8'd1);
      check("sA_mod1", bus1.NgramHV_mod1_DO, 8'b11100000);
      drive1(1'b0, 8'b0, 8'b0, 8'b0);
      tick();
      check("sA_release", {7'b0, bus1.ValidOut_SO}, 8'd0);

      // 5. clear restarts warm-up and rejects the sample offered with it
      clear1 = 1'b1;
      #1;
      check("clr_ready", {7'b0, bus1.ReadyOut_SO}, 8'd0);
      tick();
      clear1 = 1'b0;
      #1;
      check("clr_after_ready", {7'b0, bus1.ReadyOut_SO}, 8'd1);
      drive1(1'b1, 8'b00010000, 8'b0, 8'b0);
      tick();
      check("clr_sB_valid", {7'b0, bus1.ValidOut_SO}, 8'd0);
      drive1(1'b1, 8'b00001000, 8'b0, 8'b0);
      tick();
      check("clr_sC_valid", {7'b0, bus1.ValidOut_SO}, 8'd0);
      drive1(1'b1, 8'b11111111, 8'b11111111, 8'b11111111);
      clear1 = 1'b1;
      #1;
      check("clr_sD_ready", {7'b0, bus1.ReadyOut_SO}, 8'd0);
      tick();
      clear1 = 1'b0;
      check("clr_sD_valid", {7'b0, bus1.ValidOut_SO}, 8'd0);
      drive1(1'b1, 8'b00000100, 8'b0, 8'b0);
      tick();
      check("clr_sE_valid", {7'b0, bus1.ValidOut_SO}, 8'd0);
      drive1(1'b1, 8'b00000010, 8'b0, 8'b0);
      tick();
      check("clr_sF_valid", {7'b0, bus1.ValidOut_SO}, 8'd0);
      drive1(1'b1, 8'b00000001, 8'b0, 8'b0);
      tick();
      check("clr_sG_valid", {7'b0, bus1.ValidOut_SO}, 8'd1);
      check("clr_sG_mod1", bus1.NgramHV_mod1_DO, 8'b00000001);
      check("clr_sG_mod2", bus1.NgramHV_mod2_DO, 8'b00000000);
      drive1(1'b0, 8'b0, 8'b0, 8'b0);

      // 6. NGRAM_SIZE=1 is a plain register; async reset drops ValidOut
      bus2.ValidIn_SI        = 1'b1;
      bus2.SpatialHV_mod1_DI = 8'b10110000;
      tick();
      check("n1_valid", {7'b0, bus2.ValidOut_SO}, 8'd1);
      check("n1_mod1", bus2.NgramHV_mod1_DO, 8'b10110000);
      bus2.ValidIn_SI = 1'b0;
      tick();
      check("n1_hold_valid", {7'b0, bus2.ValidOut_SO}, 8'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("n1_async_valid", {7'b0, bus2.ValidOut_SO}, 8'd0);
      check("n1_async_mod1", bus2.NgramHV_mod1_DO, 8'b00000000);
      check("n3_async_valid", {7'b0, bus1.ValidOut_SO}, 8'd0);
      #2;
      rst_n = 1'b1;
      tick();
      check("n1_rearm_ready", {7'b0, bus2.ReadyOut_SO}, 8'd1);
      bus2.ValidIn_SI        = 1'b1;
      bus2.SpatialHV_mod1_DI = 8'b01010101;
      tick();
      check("n1_again_mod1", bus2.NgramHV_mod1_DO, 8'b01010101);
      bus2.ValidIn_SI = 1'b0;

      // report
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
